sc_mac_acc: RTL and testbench
=============================

Name: sc_mac_acc

Overview:
- Stochastic multiply-accumulate stage that sits directly downstream of the stochastic number generator.
- Each accepted beat carries two BITSTREAM-wide unipolar bitstreams: an activation and a weight. The block multiplies them by bitwise AND, popcounts the product and adds the count to a running sum.
- On the beat flagged last, the block presents the transaction result (sum, beat count, saturation flag) on a valid/ready output port for the next layer's quantiser.

Parameters:
- BITSTREAM, 64, bitstream length in bits (one stochastic value per beat).
- ACC_W, 16, accumulator and out_sum width in bits; must be >= $clog2(BITSTREAM)+1.
- BEAT_W, 8, beat counter width in bits.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of partial sum and pending result.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_last  input  1  beat is the final beat of the transaction.
- in_a_bits  input  BITSTREAM  activation bitstream.
- in_b_bits  input  BITSTREAM  weight bitstream.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  accumulated popcount of the transaction.
- out_beats  output  BEAT_W  number of beats in the transaction.
- out_sat  output  1  sum or beat count clamped during the transaction.

Behaviour:
- Reset (already decided): rst_n asynchronous, active-low; clock clk. Reset forces state ACCUM and clears acc, beat count, sat flag, out_valid, out_sum, out_beats and out_sat to 0.
- Accept: a beat is accepted when in_valid && in_ready.
- Per-beat arithmetic: pc = popcount(in_a_bits & in_b_bits), range 0..BITSTREAM, width $clog2(BITSTREAM)+1.
- Next sum: nsum = acc + pc, computed at ACC_W+1 bits. If nsum exceeds 2^ACC_W-1, it clamps to 2^ACC_W-1 and sat is set.
- Beat count: increments per accepted beat and saturates at 2^BEAT_W-1. Reaching that limit also sets sat.
- States: ACCUM and HOLD.
- ACCUM:
  - in_ready = 1.
  - Accepted beat with in_last = 0: acc <= nsum, count and sat update, stay in ACCUM.
  - Accepted beat with in_last = 1: out_sum <= nsum, out_beats <= count+1 (saturating), out_sat <= updated sat, out_valid <= 1. Also acc, count and sat <= 0, then go to HOLD.
- HOLD:
  - out_valid = 1; out_sum, out_beats and out_sat are stable.
  - in_ready = out_ready, so the pipeline releases in the same cycle as the result handshake.
  - out_ready = 1 with no accepted beat: out_valid <= 0, go to ACCUM.
  - out_ready = 1 with an accepted non-last beat: result retired; the beat starts a fresh sum (acc <= pc); go to ACCUM.
  - out_ready = 1 with an accepted last beat: the new single-beat result loads immediately (out_sum = pc, out_beats = 1); stay in HOLD with out_valid held at 1.
- Latency: the result is visible one cycle after the last beat is accepted.
- Throughput: one beat per cycle with no bubble when out_ready is held high.
- clear:
  - Has priority over any same-cycle beat; that beat is dropped, although in_ready still reads as computed.
  - Zeroes acc, count, sat and out_valid, and returns to ACCUM.
  - A pending result is discarded even if out_ready = 1 in the same cycle.
- Zero-product beat (pc = 0): still counted in out_beats.
- Reset mid-transaction: partial sum is lost; no output is produced.

Decomposition:
- Package sc_pkg holds:
  - typedef enum logic {ACCUM, HOLD} sc_acc_state_e;
  - the popcount width function.
- One sub-module, sc_popcount #(BITSTREAM): purely combinational adder-tree popcount, reusable by other stochastic blocks.

Test Plan:
- Single last beat, a = b = all ones -> next cycle out_valid = 1, out_sum = 64, out_beats = 1, out_sat = 0; in_ready = 0 while out_ready = 0.
- a = 0xFFFFFFFF00000000, b = 0x0000FFFFFFFF0000, in_last = 1 -> out_sum = 16, out_beats = 1.
- Three back-to-back all-ones beats, last on the third, out_ready held 1 -> out_sum = 192, out_beats = 3; a fourth last beat accepted in the handshake cycle gives out_sum = 64, out_beats = 1, with out_valid never dropping.
- ACC_W = 8, five all-ones beats -> out_sum = 255, out_sat = 1; the following transaction (one beat, pc = 10) gives out_sum = 10, out_sat = 0.
- Backpressure: result pending, out_ready low for 3 cycles with in_valid high -> in_ready = 0 and out_* stable across all 3 cycles. Then out_ready = 1 -> beat accepted in that same cycle and out_valid deasserts next cycle (non-last beat).
- Two beats accepted, then clear with in_valid high -> beat dropped; the next single last beat with pc = 5 gives out_sum = 5, out_beats = 1. Asserting rst_n low mid-transaction gives out_valid = 0 immediately.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing datapath blocks.
package sc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } sc_acc_state_e;

    // Width needed to hold a popcount of n bits (values 0..n inclusive).
    function automatic int pc_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/sc_popcount.sv
// Combinational popcount built as a balanced binary adder tree.
// The input is zero-padded up to the next power of two so every level halves cleanly.
module sc_popcount
    import sc_pkg::*;
#(
    parameter int BITSTREAM = 64
) (
    input  logic [BITSTREAM-1:0]           bits_i,
    output logic [pc_width(BITSTREAM)-1:0] count_o
);

    localparam int PW     = pc_width(BITSTREAM);
    localparam int LEVELS = $clog2(BITSTREAM);
    localparam int NPAD   = 1 << LEVELS;

    // Level 0 holds one leaf per input bit; each later level sums adjacent pairs.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [PW-1:0] node [NPAD >> l];
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < NPAD; i++) begin : g_i
                if (i < BITSTREAM) begin : g_bit
                    assign node[i] = {{(PW-1){1'b0}}, bits_i[i]};
                end else begin : g_pad
                    assign node[i] = '0;
                end
            end
        end else begin : g_sum
            for (genvar i = 0; i < (NPAD >> l); i++) begin : g_i
                assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
            end
        end
    end

    assign count_o = g_lvl[LEVELS].node[0];

endmodule

// File: rtl/sc_mac_acc.sv
// Stochastic multiply-accumulate: ANDs activation and weight bitstreams,
// popcounts the product and accumulates it across a transaction. The result
// (sum, beat count, saturation flag) is held on a valid/ready port until taken.
module sc_mac_acc
    import sc_pkg::*;
#(
    parameter int BITSTREAM = 64,
    parameter int ACC_W     = 16,
    parameter int BEAT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [BITSTREAM-1:0] in_a_bits,
    input  logic [BITSTREAM-1:0] in_b_bits,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_sum,
    output logic [BEAT_W-1:0]    out_beats,
    output logic                 out_sat
);

    localparam int PC_W = pc_width(BITSTREAM);

    // Saturating accumulate: returns {overflow, clamped sum}.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [PC_W-1:0]  p);
        logic [ACC_W:0] s;
        s = {1'b0, acc} + {{(ACC_W+1-PC_W){1'b0}}, p};
        if (s[ACC_W]) begin
            return {1'b1, {ACC_W{1'b1}}};
        end
        return s;
    endfunction

    // Saturating beat increment: returns {limit reached, new count}.
    function automatic logic [BEAT_W:0] beat_inc(input logic [BEAT_W-1:0] cnt);
        logic [BEAT_W-1:0] n;
        if (&cnt) begin
            return {1'b1, cnt};
        end
        n = cnt + 1'b1;
        return {&n, n};
    endfunction

    sc_acc_state_e     state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [BEAT_W-1:0] cnt_q;
    logic              sat_q;
    logic              out_valid_q;
    logic [ACC_W-1:0]  out_sum_q;
    logic [BEAT_W-1:0] out_beats_q;
    logic              out_sat_q;

    logic [BITSTREAM-1:0] prod;
    logic [PC_W-1:0]      pc;
    logic [ACC_W-1:0]     acc_d;
    logic [BEAT_W-1:0]    cnt_d;
    logic                 sat_d;
    logic                 sum_ovf;
    logic                 cnt_hit;
    logic                 accept;

    assign prod = in_a_bits & in_b_bits;

    sc_popcount #(
        .BITSTREAM(BITSTREAM)
    ) u_popcount (
        .bits_i (prod),
        .count_o(pc)
    );

    // Ready is free-running while accumulating; while holding a result it
    // follows out_ready so a new beat can slip in during the result handshake.
    // acc/cnt/sat are already zero in HOLD, so the same next-state math
    // produces a fresh sum there.
    always_comb begin
        in_ready         = (state_q == ACCUM) ? 1'b1 : out_ready;
        accept           = in_valid && in_ready && !clear;
        {sum_ovf, acc_d} = sat_add(acc_q, pc);
        {cnt_hit, cnt_d} = beat_inc(cnt_q);
        sat_d            = sat_q | sum_ovf | cnt_hit;
    end

    // Transaction FSM with registered result outputs; clear overrides any beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_beats_q <= '0;
            out_sat_q   <= 1'b0;
        end else if (clear) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept && in_last) begin
                        out_sum_q   <= acc_d;
                        out_beats_q <= cnt_d;
                        out_sat_q   <= sat_d;
                        out_valid_q <= 1'b1;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        sat_q       <= 1'b0;
                        state_q     <= HOLD;
                    end else if (accept) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        sat_q <= sat_d;
                    end
                end
                HOLD: begin
                    if (accept && in_last) begin
                        out_sum_q   <= acc_d;
                        out_beats_q <= cnt_d;
                        out_sat_q   <= sat_d;
                        out_valid_q <= 1'b1;
                    end else if (accept) begin
                        acc_q       <= acc_d;
                        cnt_q       <= cnt_d;
                        sat_q       <= sat_d;
                        out_valid_q <= 1'b0;
                        state_q     <= ACCUM;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_beats = out_beats_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_sc_mac_acc.sv
// Directed testbench for sc_mac_acc: a default instance plus an ACC_W=8
// instance sharing the same stimulus to exercise sum saturation.
module tb_sc_mac_acc;

    localparam int BS = 64;
    localparam logic [BS-1:0] ONES = {BS{1'b1}};

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_last;
    logic [BS-1:0] in_a_bits;
    logic [BS-1:0] in_b_bits;
    logic          out_ready;

    logic          in_ready;
    logic          out_valid;
    logic [15:0]   out_sum;
    logic [7:0]    out_beats;
    logic          out_sat;

    logic          in_ready8;
    logic          out_valid8;
    logic [7:0]    out_sum8;
    logic [7:0]    out_beats8;
    logic          out_sat8;

    int checks;
    int failures;

    sc_mac_acc #(.BITSTREAM(BS), .ACC_W(16), .BEAT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_a_bits(in_a_bits), .in_b_bits(in_b_bits),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_beats(out_beats), .out_sat(out_sat)
    );

    sc_mac_acc #(.BITSTREAM(BS), .ACC_W(8), .BEAT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready8), .in_last(in_last),
        .in_a_bits(in_a_bits), .in_b_bits(in_b_bits),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_sum(out_sum8), .out_beats(out_beats8), .out_sat(out_sat8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one beat, let it be taken on the next edge, end at edge+1.
    task automatic drive_beat(input logic [BS-1:0] a, input logic [BS-1:0] b, input logic last);
        in_valid  = 1'b1;
        in_a_bits = a;
        in_b_bits = b;
        in_last   = last;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 16'd0 || out_beats !== 8'd0 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%0b sum=%0d beats=%0d sat=%0b, want 0/0/0/0",
                     out_valid, out_sum, out_beats, out_sat);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_ones();
        out_ready = 1'b0;
        drive_beat(ONES, ONES, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd64 || out_beats !== 8'd1 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL single_ones: got v=%0b sum=%0d beats=%0d sat=%0b, want 1/64/1/0",
                     out_valid, out_sum, out_beats, out_sat);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold_in_ready_low: got %0b want 0", in_ready);
        end
        retire();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL retire_valid: got %0b want 0", out_valid);
        end
    endtask

    task automatic test_partial_overlap();
        drive_beat(64'hFFFFFFFF00000000, 64'h0000FFFFFFFF0000, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd16 || out_beats !== 8'd1) begin
            failures++;
            $display("FAIL partial_overlap: got v=%0b sum=%0d beats=%0d, want 1/16/1",
                     out_valid, out_sum, out_beats);
        end
        retire();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_a_bits = ONES;
            in_b_bits = ONES;
            in_last   = (i == 2);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready beat%0d: got %0b want 1", i, in_ready);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd192 || out_beats !== 8'd3) begin
            failures++;
            $display("FAIL b2b_result: got v=%0b sum=%0d beats=%0d, want 1/192/3",
                     out_valid, out_sum, out_beats);
        end
        // fourth beat, last, accepted during the result handshake
        in_last = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_handshake_ready: got %0b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd64 || out_beats !== 8'd1) begin
            failures++;
            $display("FAIL b2b_reload: got v=%0b sum=%0d beats=%0d, want 1/64/1",
                     out_valid, out_sum, out_beats);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: got %0b want 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) drive_beat(ONES, ONES, (i == 4));
        checks++;
        if (out_sum8 !== 8'd255 || out_sat8 !== 1'b1 || out_beats8 !== 8'd5) begin
            failures++;
            $display("FAIL sat_acc8: got sum=%0d sat=%0b beats=%0d, want 255/1/5",
                     out_sum8, out_sat8, out_beats8);
        end
        checks++;
        if (out_sum !== 16'd320 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL nosat_acc16: got sum=%0d sat=%0b, want 320/0", out_sum, out_sat);
        end
        retire();
        drive_beat(64'h3FF, ONES, 1'b1);
        checks++;
        if (out_sum8 !== 8'd10 || out_sat8 !== 1'b0 || out_beats8 !== 8'd1) begin
            failures++;
            $display("FAIL sat_cleared: got sum=%0d sat=%0b beats=%0d, want 10/0/1",
                     out_sum8, out_sat8, out_beats8);
        end
        retire();
    endtask

    task automatic test_beat_saturation();
        for (int i = 0; i < 260; i++) drive_beat('0, ONES, (i == 259));
        checks++;
        if (out_valid !== 1'b1 || out_beats !== 8'd255 || out_sat !== 1'b1 || out_sum !== 16'd0) begin
            failures++;
            $display("FAIL beat_sat: got v=%0b beats=%0d sat=%0b sum=%0d, want 1/255/1/0",
                     out_valid, out_beats, out_sat, out_sum);
        end
        retire();
    endtask

    task automatic test_backpressure();
        drive_beat(64'hFF, 64'hFF, 1'b1);
        in_valid  = 1'b1;
        in_a_bits = 64'hF;
        in_b_bits = ONES;
        in_last   = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 16'd8 || out_beats !== 8'd1) begin
                failures++;
                $display("FAIL backpressure cyc%0d: got rdy=%0b v=%0b sum=%0d beats=%0d, want 0/1/8/1",
                         i, in_ready, out_valid, out_sum, out_beats);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_ready: got %0b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL release_valid: got %0b want 0", out_valid);
        end
        drive_beat(64'h1, ONES, 1'b1);
        checks++;
        if (out_sum !== 16'd5 || out_beats !== 8'd2) begin
            failures++;
            $display("FAIL release_beat_kept: got sum=%0d beats=%0d, want 5/2", out_sum, out_beats);
        end
        retire();
    endtask

    task automatic test_clear();
        drive_beat(64'h7F, ONES, 1'b0);
        drive_beat(64'h7F, ONES, 1'b0);
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_a_bits = 64'h7;
        in_b_bits = ONES;
        in_last   = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL clear_ready: got %0b want 1", in_ready);
        end
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear_drop: got %0b want 0", out_valid);
        end
        drive_beat(64'h1F, ONES, 1'b1);
        checks++;
        if (out_sum !== 16'd5 || out_beats !== 8'd1) begin
            failures++;
            $display("FAIL clear_fresh: got sum=%0d beats=%0d, want 5/1", out_sum, out_beats);
        end
        // pending result is discarded by clear even with out_ready high
        clear     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        clear     = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear_pending: got %0b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        drive_beat(64'h7F, ONES, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 16'd0) begin
            failures++;
            $display("FAIL async_reset: got v=%0b sum=%0d, want 0/0", out_valid, out_sum);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive_beat(64'h1F, ONES, 1'b1);
        checks++;
        if (out_sum !== 16'd5 || out_beats !== 8'd1) begin
            failures++;
            $display("FAIL reset_partial_lost: got sum=%0d beats=%0d, want 5/1", out_sum, out_beats);
        end
        retire();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_a_bits = '0;
        in_b_bits = '0;
        out_ready = 1'b0;
        test_reset();
        test_single_ones();
        test_partial_overlap();
        test_back_to_back();
        test_saturation();
        test_beat_saturation();
        test_backpressure();
        test_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
